// File: rtl/mem_sad_wb_backend.sv
// MEM / SAD1 / SAD2 / SAD3 back end with internal data memory and write-back mux.
// Define SAD_UNIT_EN to build the SAD datapath; otherwise SAD1-SAD3 are pure delay stages.
module mem_sad_wb_backend #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        iSAD,
  input  logic        iRegWriteCtrl,
  input  logic        iMove,
  input  logic        iMemRead,
  input  logic        iZero,
  input  logic        iHiLoWrite,
  input  logic [1:0]  iSEMux,
  input  logic [1:0]  iMemWrite,
  input  logic [2:0]  iMemToReg,
  input  logic [31:0] iPCPlus4,
  input  logic [31:0] iALUResult,
  input  logic [31:0] iReadReg1,
  input  logic [31:0] iReadReg2,
  input  logic [31:0] iHi,
  input  logic [31:0] iLo,
  input  logic [63:0] iHiLoResult,
  input  logic [4:0]  iRegDstResult,
  output logic        oRegWrite,
  output logic [4:0]  oWriteAddr,
  output logic [31:0] oWriteData,
  output logic        oHiLoWrite,
  output logic [31:0] oNewHi,
  output logic [31:0] oNewLo,
  output logic [4:0]  oMEMrd,
  output logic [4:0]  oSAD1rd,
  output logic [4:0]  oSAD2rd,
  output logic [4:0]  oSAD3rd,
  output logic        oMEMRegWrite,
  output logic        oSAD1RegWrite,
  output logic        oSAD2RegWrite,
  output logic        oSAD3RegWrite
);
  localparam int unsigned AW = $clog2(DMEM_WORDS);

  typedef struct packed {
    logic        rw;
    logic        hlw;
    logic [2:0]  mtr;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [4:0]  rd;
    logic [31:0] ld;
  } wb_t;

  wb_t         m, s1, s2, s3;
  logic [1:0]  m_semux, m_mw;
  logic [31:0] m_rr2;

  logic [31:0] dmem [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic        in_range, store_en;
  logic [1:0]  bsel;
  logic [31:0] raw, wdata, load_data;
  logic [15:0] half;
  logic [7:0]  byte_sel;

  // MEM stage: capture the whole bundle, resolving the conditional move here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m       <= '0;
      m_semux <= '0;
      m_mw    <= '0;
      m_rr2   <= '0;
    end else begin
      m       <= '{rw: iRegWriteCtrl & (~iMove | iZero), hlw: iHiLoWrite, mtr: iMemToReg,
                   pc4: iPCPlus4, alu: iALUResult, hi: iHi, lo: iLo, hilo: iHiLoResult,
                   rd: iRegDstResult, ld: '0};
      m_semux <= iSEMux;
      m_mw    <= iMemWrite;
      m_rr2   <= iReadReg2;
    end
  end

  assign idx      = m.alu[AW+1:2];
  assign in_range = (m.alu[31:AW+2] == '0);
  assign bsel     = m.alu[1:0];
  assign raw      = in_range ? dmem[idx] : '0;
  assign half     = bsel[1] ? raw[31:16] : raw[15:0];
  assign byte_sel = raw[{bsel, 3'b000} +: 8];

  // Read-modify-write merge so sub-word stores reuse the combinational read port.
  always_comb begin
    wdata = raw;
    case (m_mw)
      2'b01:   wdata = m_rr2;
      2'b10:   if (bsel[1]) wdata[31:16] = m_rr2[15:0];
               else         wdata[15:0]  = m_rr2[15:0];
      2'b11:   wdata[{bsel, 3'b000} +: 8] = m_rr2[7:0];
      default: wdata = raw;
    endcase
  end

  always_comb begin
    case (m_semux)
      2'b00:   load_data = raw;
      2'b01:   load_data = {{16{half[15]}}, half};
      2'b10:   load_data = {{24{byte_sel[7]}}, byte_sel};
      default: load_data = {24'h000000, byte_sel};
    endcase
  end

`ifdef SAD_UNIT_EN
  logic              m_sad;
  logic [31:0]       m_rr1, s1_rr1, s2_rr1, s3_sad;
  logic [3:0][7:0]   diff, s1_d;
  logic [8:0]        s2_p0, s2_p1;
  logic              unused_inputs;

  assign unused_inputs = iMemRead;
  assign store_en = ~Reset & (m_mw != 2'b00) & in_range & ~m_sad;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      diff[i] = (raw[8*i +: 8] > m_rr2[8*i +: 8]) ? raw[8*i +: 8] - m_rr2[8*i +: 8]
                                                   : m_rr2[8*i +: 8] - raw[8*i +: 8];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      m_sad  <= 1'b0;
      m_rr1  <= '0;
      s1_d   <= '0;
      s1_rr1 <= '0;
      s2_p0  <= '0;
      s2_p1  <= '0;
      s2_rr1 <= '0;
      s3_sad <= '0;
    end else begin
      m_sad  <= iSAD;
      m_rr1  <= iReadReg1;
      s1_d   <= diff;
      s1_rr1 <= m_rr1;
      s2_p0  <= {1'b0, s1_d[0]} + {1'b0, s1_d[1]};
      s2_p1  <= {1'b0, s1_d[2]} + {1'b0, s1_d[3]};
      s2_rr1 <= s1_rr1;
      s3_sad <= s2_rr1 + {23'h0, s2_p0} + {23'h0, s2_p1};
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{iSAD, iMemRead, iReadReg1};
  assign store_en = ~Reset & (m_mw != 2'b00) & in_range;
`endif

  always_ff @(posedge Clk) begin
    if (store_en) dmem[idx] <= wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1    <= m;
      s1.ld <= load_data;
      s2    <= s1;
      s3    <= s2;
    end
  end

  always_comb begin
    case (s3.mtr)
      3'b001:  oWriteData = s3.ld;
      3'b010:  oWriteData = s3.pc4;
      3'b011:  oWriteData = s3.hi;
      3'b100:  oWriteData = s3.lo;
`ifdef SAD_UNIT_EN
      3'b101:  oWriteData = s3_sad;
`else
      3'b101:  oWriteData = '0;
`endif
      default: oWriteData = s3.alu;
    endcase
  end

  assign oRegWrite     = s3.rw;
  assign oWriteAddr    = s3.rd;
  assign oHiLoWrite    = s3.hlw;
  assign oNewHi        = s3.hilo[63:32];
  assign oNewLo        = s3.hilo[31:0];
  assign oMEMrd        = m.rd;
  assign oSAD1rd       = s1.rd;
  assign oSAD2rd       = s2.rd;
  assign oSAD3rd       = s3.rd;
  assign oMEMRegWrite  = m.rw;
  assign oSAD1RegWrite = s1.rw;
  assign oSAD2RegWrite = s2.rw;
  assign oSAD3RegWrite = s3.rw;
endmodule
